if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage control decoder. It owns the PC and drives the instruction memory address. It latches the fetched word and PC+4 into IF/ID for decode. It handles hazard stalls, branch redirects and instruction-memory wait states by holding state or injecting the all-zero NOP word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word injected as a bubble; the decoder treats it as NOP.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  current PC, word-aligned ([1:0] always 0).
- imem_data  in  32  instruction word at imem_addr.
- imem_ready  in  1  imem_data is valid this cycle.
- stall  in  1  hazard unit: hold PC and IF/ID (load-use).
- br_taken  in  1  ID stage: branch resolved taken this cycle.
- br_target  in  32  branch target; bits [1:0] ignored.
- if_id_ir  out  32  registered instruction to decoder.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on the rising edge of clk.
- Reset values:
  - PC = RESET_PC.
  - if_id_ir = NOP_WORD, if_id_pc4 = 0, if_id_valid = 0.
  - FSM = BOOT.
  - Stats counters (if enabled) = 0.
- imem_addr = {PC[31:2],2'b00}, combinational from PC. Memory is zero-latency when imem_ready=1.
- FSM states:
  - BOOT: one cycle after reset, inserts a bubble, PC held. Always goes to FETCH.
  - FETCH: normal operation.
  - WAIT: imem_ready was low; waiting for memory.
- Per-cycle priority in FETCH/WAIT (highest first):
  1. reset.
  2. br_taken: PC <= {br_target[31:2],2'b00}; IF/ID <= bubble; state = FETCH. Overrides stall and an outstanding wait.
  3. stall: PC and IF/ID hold their values; state unchanged.
  4. !imem_ready: PC holds; IF/ID <= bubble; state = WAIT.
  5. Otherwise: PC <= PC+4; if_id_ir <= imem_data; if_id_pc4 <= PC+4; if_id_valid <= 1; state = FETCH.
- Bubble means if_id_ir = NOP_WORD, if_id_valid = 0, if_id_pc4 = 0.
- Latency: the word at address A appears on if_id_ir one cycle after imem_addr = A with imem_ready = 1 and no stall or branch.
- PC+4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag.
- An imem_data word of NOP_WORD fetched normally is passed through with valid = 1.
- Reset asserted mid-stall or mid-wait: clean return to the reset state on the next edge.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds three 32-bit outputs: stat_fetched (count of valid IF/ID loads), stat_stall_cycles (cycles where stall is the winning condition, or !imem_ready), stat_flushes (count of br_taken). All saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, these ports and counters do not exist. The rest of the behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - NOP_WORD and RESET_PC constants.
  - The fetch FSM state enum (BOOT, FETCH, WAIT).
  - The IF/ID bundle typedef (ir, pc4, valid).
- One natural sub-module, pc_reg: PC register with load, hold and increment, plus the next-PC mux.
- The IF/ID latch and FSM stay in the top module.

Test Plan:
- Reset, then imem_ready = 1 with words 0xE0810002, 0xE5912004: BOOT bubble first; if_id_ir = 0xE0810002 with pc4 = 4, then 0xE5912004 with pc4 = 8; imem_addr steps 0, 4, 8.
- stall held high for 2 cycles at PC = 8: imem_addr stays 8; if_id_ir and pc4 unchanged; normal flow resumes the cycle after stall drops.
- br_taken = 1 with br_target = 0x103 at PC = 0x10: next imem_addr = 0x100; if_id_valid = 0 and if_id_ir = 0; the next cycle fetches from 0x100.
- br_taken and stall asserted together: the branch wins (PC = target, bubble in IF/ID).
- imem_ready low for 3 cycles: PC held, 3 bubbles, state WAIT; when ready returns, the word is latched and PC advances by 4.
- With FETCH_STATS_EN defined, run the scenarios above: counters match the expected fetched/stall/flush totals; PC = 0xFFFFFFFC advances to 0.

Source files
------------

// File: rtl/if_id_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: bubble word, reset PC,
// fetch FSM state encoding and the IF/ID register bundle.
package if_id_fetch_stage_pkg;

    localparam logic [31:0] PKG_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PKG_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage_pc_reg.sv
// Program counter with branch load, increment and hold, plus its next-PC mux.
// Only the word-address bits of the branch target are taken; the low two
// PC bits are therefore always zero.
module if_id_fetch_stage_pc_reg
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PKG_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [29:0] target_word,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    logic [31:0] pc_p0;
    logic [31:0] pc_d;

    // PC+4 wraps modulo 2^32 with no carry-out.
    assign pc4 = pc_p0 + 32'd4;
    assign pc  = pc_p0;

    // Next-PC mux: branch load beats increment; otherwise hold.
    always_comb begin
        pc_d = pc_p0;
        if (load) begin
            pc_d = {target_word, 2'b00};
        end else if (advance) begin
            pc_d = pc4;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_p0 <= pc_d;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Handles branch redirect, hazard stall and memory wait states by holding
// state or injecting a bubble (NOP_WORD, valid=0, pc4=0).
// Optional macro FETCH_STATS_EN adds saturating fetch/stall/flush counters.
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PKG_RESET_PC,
    parameter logic [31:0] NOP_WORD = PKG_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_pc4,
`ifdef FETCH_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_flushes,
`endif
    output logic        if_id_valid
);

    localparam if_id_t BUBBLE = '{ir: NOP_WORD, pc4: 32'd0, valid: 1'b0};

    fetch_state_e state_q, state_d;
    if_id_t       if_id_p1, if_id_d;
    logic [31:0]  pc_p0, pc4_p0;
    logic         pc_load, pc_advance;
    logic         ev_fetch, ev_stall, ev_flush;
    logic         unused_low_bits;

    assign unused_low_bits = ^{br_target[1:0], pc_p0[1:0], ev_fetch, ev_stall, ev_flush};

    if_id_fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (pc_load),
        .advance     (pc_advance),
        .target_word (br_target[31:2]),
        .pc          (pc_p0),
        .pc4         (pc4_p0)
    );

    assign imem_addr   = {pc_p0[31:2], 2'b00};
    assign if_id_ir    = if_id_p1.ir;
    assign if_id_pc4   = if_id_p1.pc4;
    assign if_id_valid = if_id_p1.valid;

    // Next-state, IF/ID next value and PC control, in priority order.
    always_comb begin
        state_d    = state_q;
        if_id_d    = if_id_p1;
        pc_load    = 1'b0;
        pc_advance = 1'b0;
        ev_fetch   = 1'b0;
        ev_stall   = 1'b0;
        ev_flush   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if_id_d = BUBBLE;
            end
            ST_FETCH, ST_WAIT: begin
                if (br_taken) begin
                    pc_load  = 1'b1;
                    if_id_d  = BUBBLE;
                    state_d  = ST_FETCH;
                    ev_flush = 1'b1;
                end else if (stall) begin
                    ev_stall = 1'b1;
                end else if (!imem_ready) begin
                    if_id_d  = BUBBLE;
                    state_d  = ST_WAIT;
                    ev_stall = 1'b1;
                end else begin
                    pc_advance = 1'b1;
                    if_id_d    = '{ir: imem_data, pc4: pc4_p0, valid: 1'b1};
                    state_d    = ST_FETCH;
                    ev_fetch   = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
                if_id_d = BUBBLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_p1 <= BUBBLE;
        end else begin
            if_id_p1 <= if_id_d;
        end
    end

`ifdef FETCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched      <= 32'd0;
            stat_stall_cycles <= 32'd0;
            stat_flushes      <= 32'd0;
        end else begin
            if (ev_fetch) stat_fetched      <= sat_inc(stat_fetched);
            if (ev_stall) stat_stall_cycles <= sat_inc(stat_stall_cycles);
            if (ev_flush) stat_flushes      <= sat_inc(stat_flushes);
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed test-plan sequences then
// randomized traffic against a rule-level reference model.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_stall_cycles, stat_flushes;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] n_fetch;
        logic [31:0] n_stall;
        logic [31:0] n_flush;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: expected post-edge values.
    logic [31:0] m_pc, m_ir, m_pc4;
    logic        m_valid, m_boot;
    logic [31:0] m_fetch, m_stall, m_flush;

    if_id_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .if_id_ir    (if_id_ir),
        .if_id_pc4   (if_id_pc4),
`ifdef FETCH_STATS_EN
        .stat_fetched      (stat_fetched),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flushes      (stat_flushes),
`endif
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] inc_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // Apply one cycle of inputs, advance the model, queue the expectation.
    task automatic step(input logic rst, input logic st, input logic br,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] data);
        exp_t e;
        reset = rst; stall = st; br_taken = br; br_target = tgt;
        imem_ready = rdy; imem_data = data;
        if (rst) begin
            m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_boot = 1'b1;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_flush = inc_sat(m_flush);
        end else if (st) begin
            m_stall = inc_sat(m_stall);
        end else if (!rdy) begin
            m_ir = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_stall = inc_sat(m_stall);
        end else begin
            m_ir = data; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetch = inc_sat(m_fetch);
        end
        e.addr = m_pc; e.ir = m_ir; e.pc4 = m_pc4; e.valid = m_valid;
        e.n_fetch = m_fetch; e.n_stall = m_stall; e.n_flush = m_flush;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new IF/ID value every cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("if_id_ir", if_id_ir, e.ir);
            chk("if_id_pc4", if_id_pc4, e.pc4);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
`ifdef FETCH_STATS_EN
            chk("stat_fetched", stat_fetched, e.n_fetch);
            chk("stat_stall_cycles", stat_stall_cycles, e.n_stall);
            chk("stat_flushes", stat_flushes, e.n_flush);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        m_pc = 0; m_ir = 0; m_pc4 = 0; m_valid = 0; m_boot = 1;
        m_fetch = 0; m_stall = 0; m_flush = 0;
        reset = 1'b1; stall = 0; br_taken = 0; br_target = 0; imem_ready = 1; imem_data = 0;

        // Reset, boot bubble, two fetches, then PC 8.
        step(1, 0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 1, 32'hE081_0002);
        step(0, 0, 0, 0, 1, 32'hE591_2004);
        // Stall two cycles at PC 8, then resume.
        step(0, 1, 0, 0, 1, 32'h1111_1111);
        step(0, 1, 0, 0, 1, 32'h2222_2222);
        step(0, 0, 0, 0, 1, 32'h0000_0008);
        step(0, 0, 0, 0, 1, 32'h0000_000C);
        // PC 0x10: branch to 0x103 -> 0x100, then fetch there.
        step(0, 0, 1, 32'h103, 1, 32'h0000_0010);
        step(0, 0, 0, 0, 1, 32'hAAAA_0100);
        // Branch together with stall: branch wins.
        step(0, 1, 1, 32'h200, 1, 32'h5555_5555);
        step(0, 0, 0, 0, 1, 32'hAAAA_0200);
        // Memory not ready for three cycles, then word latched.
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'hBBBB_0204);
        // A fetched NOP word stays valid.
        step(0, 0, 0, 0, 1, 32'h0000_0000);
        // PC wrap at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'hCCCC_FFFC);
        step(0, 0, 0, 0, 1, 32'hCCCC_0000);
        // Reset mid-wait and mid-stall.
        step(0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h1234_5678);
        step(0, 1, 0, 0, 1, 32'h0);
        step(1, 1, 0, 0, 1, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 d);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
